// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet transmit path.
package eth_pkg;

    localparam int ETH_MIN_FRAME_BYTES = 60;
    localparam int ETH_WORD_BYTES      = 4;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
    } avst_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        PAD  = 2'd2
    } pad_state_t;

    // Keep mask for an eop word; empty bytes sit at the low end of the word.
    function automatic logic [31:0] byte_mask(input logic [1:0] empty);
        logic [31:0] mask;
        case (empty)
            2'd0:    mask = 32'hFFFF_FFFF;
            2'd1:    mask = 32'hFFFF_FF00;
            2'd2:    mask = 32'hFFFF_0000;
            2'd3:    mask = 32'hFF00_0000;
            default: mask = 32'hFFFF_FFFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/eth_tx_pad.sv
// Pads short Ethernet frames with zero bytes up to the minimum length, one registered stage.
// Optional frame/pad statistics counters are built when TX_PAD_STATS_EN is defined.
module eth_tx_pad
    import eth_pkg::*;
#(
    parameter int MIN_FRAME_BYTES = ETH_MIN_FRAME_BYTES,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] avsi_data,
    input  logic                  avsi_valid,
    output logic                  avsi_ready,
    input  logic                  avsi_sop,
    input  logic                  avsi_eop,
    input  logic [1:0]            avsi_empty,
    output logic [DATA_WIDTH-1:0] avso_tse_data,
    output logic                  avso_tse_valid,
    input  logic                  avso_tse_ready,
    output logic                  avso_tse_sop,
    output logic                  avso_tse_eop,
    output logic [1:0]            avso_tse_empty
`ifdef TX_PAD_STATS_EN
    ,
    output logic [31:0]           stat_frames,
    output logic [31:0]           stat_padded
`endif
);

    localparam int MIN_WORDS = MIN_FRAME_BYTES / ETH_WORD_BYTES;
    localparam int CNT_W     = $clog2(MIN_WORDS + 1) + 1;
    localparam logic [CNT_W-1:0] MIN_WORDS_C = CNT_W'(MIN_WORDS);
    localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);

    pad_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    avst_word_t       out_q, out_d;
    logic             valid_q, valid_d;
    logic             run_q;

    logic             load_en_s;
    logic             in_ready_s;
    logic             enter_pad_s;
    logic             pad_last_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [CNT_W-1:0] n_s;

    // Holds the input closed until the first clock after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // State, word counter and output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic: forward, mask the short eop word, then emit zero fill.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        valid_d     = valid_q;
        in_ready_s  = 1'b0;
        enter_pad_s = 1'b0;
        load_en_s   = !valid_q || avso_tse_ready;
        pad_last_s  = (cnt_q + ONE_C) == MIN_WORDS_C;

        if (cnt_q >= MIN_WORDS_C) begin
            cnt_inc_s = MIN_WORDS_C;
        end else begin
            cnt_inc_s = cnt_q + ONE_C;
        end

        // A sop always restarts the count, even mid-frame.
        if ((state_q == PASS) && !avsi_sop) begin
            n_s = cnt_inc_s;
        end else begin
            n_s = ONE_C;
        end

        case (state_q)
            IDLE, PASS: begin
                in_ready_s = load_en_s && run_q;
                if (load_en_s) begin
                    valid_d = 1'b0;
                end else begin
                    valid_d = valid_q;
                end
                if (avsi_valid && in_ready_s && (avsi_sop || (state_q == PASS))) begin
                    valid_d     = 1'b1;
                    cnt_d       = n_s;
                    out_d.data  = avsi_data;
                    out_d.sop   = avsi_sop;
                    out_d.eop   = avsi_eop;
                    out_d.empty = avsi_empty;
                    if (!avsi_eop) begin
                        state_d = PASS;
                    end else if (n_s >= MIN_WORDS_C) begin
                        state_d = IDLE;
                    end else begin
                        out_d.data  = avsi_data & byte_mask(avsi_empty);
                        out_d.eop   = 1'b0;
                        out_d.empty = 2'd0;
                        state_d     = PAD;
                        enter_pad_s = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            PAD: begin
                if (load_en_s) begin
                    valid_d     = 1'b1;
                    cnt_d       = cnt_q + ONE_C;
                    out_d.data  = 32'h0000_0000;
                    out_d.sop   = 1'b0;
                    out_d.eop   = pad_last_s;
                    out_d.empty = 2'd0;
                    if (pad_last_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = PAD;
                    end
                end else begin
                    state_d = PAD;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign avsi_ready     = in_ready_s;
    assign avso_tse_data  = out_q.data;
    assign avso_tse_valid = valid_q;
    assign avso_tse_sop   = out_q.sop;
    assign avso_tse_eop   = out_q.eop;
    assign avso_tse_empty = out_q.empty;

`ifdef TX_PAD_STATS_EN
    logic [31:0] stat_frames_q;
    logic [31:0] stat_padded_q;

    // Wrapping counters of forwarded and padded frames.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_frames_q <= 32'd0;
            stat_padded_q <= 32'd0;
        end else begin
            if (valid_q && avso_tse_ready && out_q.eop) begin
                stat_frames_q <= stat_frames_q + 32'd1;
            end else begin
                stat_frames_q <= stat_frames_q;
            end
            if (enter_pad_s) begin
                stat_padded_q <= stat_padded_q + 32'd1;
            end else begin
                stat_padded_q <= stat_padded_q;
            end
        end
    end

    assign stat_frames = stat_frames_q;
    assign stat_padded = stat_padded_q;
`else
    logic stats_unused_s;
    assign stats_unused_s = enter_pad_s;
`endif

endmodule
